// File: rtl/force_sched_pkg.sv
// Shared types and helpers for the force_sched override scheduler.
// The optional owner timeout is enabled by defining FORCE_SCHED_TIMEOUT_EN.
package force_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FORCED = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam int SETTLE_W = 4;

    // Index of the lowest set bit; vectors narrower than 16 are zero-extended by the caller.
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/force_sched_prio.sv
// Combinational fixed-priority encoder: the lowest-index active request wins.
module force_sched_prio
    import force_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic [N-1:0]         onehot_o,
    output logic                 any_o
);
    localparam int IW = $clog2(N);

    logic [15:0] req_ext;

    assign req_ext  = 16'(req_i);
    assign idx_o    = IW'(lowest_idx(req_ext));
    assign onehot_o = req_i & (~req_i + 1'b1);
    assign any_o    = |req_i;

endmodule

// File: rtl/force_sched.sv
// Arbitrates one shared force/release override path on a W-bit net among N requesters.
// Define FORCE_SCHED_TIMEOUT_EN to auto-release an owner after MAX_HOLD forced cycles.
module force_sched
    import force_sched_pkg::*;
#(
    parameter int W          = 8,
    parameter int N          = 4,
    parameter int SETTLE_CYC = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         drv_val,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_val,
    input  logic [N-1:0]         rel,
    output logic [W-1:0]         net_out,
    output logic                 forced,
    output logic [$clog2(N)-1:0] owner,
    output logic [N-1:0]         grant,
    output logic                 expired
);
    localparam int IW = $clog2(N);

    state_e              state_q, state_d;
    logic [W-1:0]        force_q, force_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [N-1:0]        grant_q, grant_d;
    logic                expired_q, expired_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_onehot;
    logic          win_any;
    logic          owner_req, owner_rel, hold_hit;
    logic [W-1:0]  owner_val, win_val;

    force_sched_prio #(.N(N)) u_prio (
        .req_i    (req),
        .idx_o    (win_idx),
        .onehot_o (win_onehot),
        .any_o    (win_any)
    );

    assign owner_req = req[owner_q];
    assign owner_rel = rel[owner_q];
    assign owner_val = req_val[owner_q*W +: W];
    assign win_val   = req_val[win_idx*W +: W];

`ifdef FORCE_SCHED_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_q, hold_d;

    assign hold_hit = (hold_q == HW'(MAX_HOLD - 1));

    // Held at zero while idle so every grant starts a fresh count; re-force does not restart it.
    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE) begin
            hold_d = '0;
        end else if (state_q == FORCED) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    // Without the timeout MAX_HOLD has no effect and the owner may hold indefinitely.
    assign hold_hit = (MAX_HOLD < 0);
`endif

    always_comb begin
        state_d   = state_q;
        force_d   = force_q;
        owner_d   = owner_q;
        settle_d  = settle_q;
        grant_d   = '0;
        expired_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = FORCED;
                    force_d = win_val;
                    owner_d = win_idx;
                    grant_d = win_onehot;
                end
            end
            FORCED: begin
                // A genuine release beats the timeout, so expired only flags auto-releases.
                if (owner_rel || hold_hit) begin
                    state_d   = SETTLE;
                    settle_d  = SETTLE_W'(SETTLE_CYC);
                    expired_d = !owner_rel;
                end else if (owner_req) begin
                    force_d = owner_val;
                end
            end
            SETTLE: begin
                settle_d = settle_q - 1'b1;
                if (settle_q <= SETTLE_W'(1)) begin
                    state_d  = IDLE;
                    settle_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            force_q   <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            expired_q <= 1'b0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            force_q   <= force_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            expired_q <= expired_d;
            settle_q  <= settle_d;
        end
    end

    assign forced  = (state_q == FORCED);
    assign net_out = forced ? force_q : drv_val;
    assign owner   = owner_q;
    assign grant   = grant_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_force_sched.sv
// Scoreboard bench for force_sched: directed scenarios followed by random traffic.
// Honours FORCE_SCHED_TIMEOUT_EN the same way the design does (MAX_HOLD=4 here).
module tb_force_sched;

    localparam int W          = 8;
    localparam int N          = 4;
    localparam int SETTLE_CYC = 1;
    localparam int MAX_HOLD   = 4;

    typedef struct {
        logic [W-1:0] net;
        logic         frc;
        logic [1:0]   own;
        logic [N-1:0] gnt;
        logic         exp;
    } expect_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   drv_val;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_val;
    logic [N-1:0]   rel;
    logic [W-1:0]   net_out;
    logic           forced;
    logic [1:0]     owner;
    logic [N-1:0]   grant;
    logic           expired;

    expect_t sbQ[$];
    int compareCount = 0;
    int failCount    = 0;

    // Reference model: who holds the net, how many more edges must pass before a grant.
    int           mOwner;
    int           mLastOwner;
    logic [W-1:0] mVal;
    int           mWait;
    int           mHeld;
    logic [N-1:0] mGrant;
    logic         mExpired;

    force_sched #(
        .W(W), .N(N), .SETTLE_CYC(SETTLE_CYC), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .drv_val (drv_val),
        .req     (req),
        .req_val (req_val),
        .rel     (rel),
        .net_out (net_out),
        .forced  (forced),
        .owner   (owner),
        .grant   (grant),
        .expired (expired)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mOwner     = -1;
        mLastOwner = 0;
        mVal       = '0;
        mWait      = 0;
        mHeld      = 0;
        mGrant     = '0;
        mExpired   = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs that were stable before it.
    task automatic modelStep();
        int pick;
        mGrant   = '0;
        mExpired = 1'b0;
        if (!rst_n) begin
            modelReset();
        end else if (mOwner >= 0) begin
            if (rel[mOwner]) begin
                mOwner = -1;
                mWait  = SETTLE_CYC;
            end
`ifdef FORCE_SCHED_TIMEOUT_EN
            else if (mHeld == MAX_HOLD) begin
                mOwner   = -1;
                mWait    = SETTLE_CYC;
                mExpired = 1'b1;
            end
`endif
            else begin
                if (req[mOwner]) mVal = req_val[mOwner*W +: W];
                mHeld++;
            end
        end else if (mWait > 0) begin
            mWait--;
        end else if (req != '0) begin
            pick = -1;
            for (int i = 0; i < N; i++) begin
                if (req[i] && pick < 0) pick = i;
            end
            mOwner     = pick;
            mLastOwner = pick;
            mVal       = req_val[pick*W +: W];
            mGrant     = N'(1) << pick;
            mHeld      = 1;
        end
    endtask

    task automatic applyStimulus(input logic rstn, input logic [W-1:0] drv,
                                 input logic [N-1:0] rq, input logic [N*W-1:0] vals,
                                 input logic [N-1:0] rl);
        expect_t e;
        @(posedge clk);
        modelStep();
        #1;
        rst_n   = rstn;
        drv_val = drv;
        req     = rq;
        req_val = vals;
        rel     = rl;
        if (!rstn) modelReset();
        e.net = (mOwner >= 0) ? mVal : drv;
        e.frc = (mOwner >= 0);
        e.own = 2'(mLastOwner);
        e.gnt = mGrant;
        e.exp = mExpired;
        sbQ.push_back(e);
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checkField("net_out", 32'(net_out), 32'(e.net));
        checkField("forced",  32'(forced),  32'(e.frc));
        checkField("owner",   32'(owner),   32'(e.own));
        checkField("grant",   32'(grant),   32'(e.gnt));
        checkField("expired", 32'(expired), 32'(e.exp));
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (sbQ.size() > 0) begin
            checkOutput(sbQ.pop_front());
        end
    end

    initial begin
        rst_n   = 1'b0;
        drv_val = 8'h11;
        req     = '0;
        req_val = '0;
        rel     = '0;
        modelReset();

        // Reset, then idle with the driver passing straight through.
        applyStimulus(0, 8'h11, 4'b0000, 32'h0, 4'b0000);
        applyStimulus(0, 8'h11, 4'b0000, 32'h0, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'h0, 4'b0000);
        applyStimulus(1, 8'h22, 4'b0000, 32'h0, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'h0, 4'b0000);

        // Single force and release by requester 2.
        applyStimulus(1, 8'h11, 4'b0100, 32'h0001_0000, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'h0001_0000, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'h0001_0000, 4'b0100);
        repeat (3) applyStimulus(1, 8'h11, 4'b0000, 32'h0, 4'b0000);

        // Contention between 1 and 3; 3 waits through the settle window.
        applyStimulus(1, 8'h11, 4'b1010, 32'hA500_1000, 4'b0000);
        applyStimulus(1, 8'h11, 4'b1010, 32'hA500_1000, 4'b0000);
        applyStimulus(1, 8'h11, 4'b1000, 32'hA500_1000, 4'b0010);
        repeat (3) applyStimulus(1, 8'h11, 4'b1000, 32'hA500_1000, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'hA500_1000, 4'b1000);
        repeat (3) applyStimulus(1, 8'h11, 4'b0000, 32'h0, 4'b0000);

        // Non-owner release is ignored; owner re-forces a new value.
        applyStimulus(1, 8'h11, 4'b0001, 32'h0000_0001, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'h0000_0001, 4'b1000);
        applyStimulus(1, 8'h11, 4'b0001, 32'h0000_007F, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'h0000_007F, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0001, 32'h0000_0055, 4'b0001);
        repeat (3) applyStimulus(1, 8'h11, 4'b0000, 32'h0, 4'b0000);

        // Reset while forced drops the override at once.
        applyStimulus(1, 8'h11, 4'b0001, 32'h0000_0001, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'h0000_0001, 4'b0000);
        applyStimulus(0, 8'h33, 4'b0000, 32'h0000_0001, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'h0, 4'b0000);

        // Long hold: exercises the timeout when it is built in.
        repeat (14) applyStimulus(1, 8'h11, 4'b0001, 32'h0000_0001, 4'b0000);
        applyStimulus(1, 8'h11, 4'b0000, 32'h0000_0001, 4'b0001);
        repeat (3) applyStimulus(1, 8'h11, 4'b0000, 32'h0, 4'b0000);

        // Random traffic with occasional resets.
        for (int k = 0; k < 500; k++) begin
            applyStimulus(($urandom_range(0, 79) != 0), 8'($urandom),
                          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                          $urandom,
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
        end

        for (int k = 0; k < 5 && sbQ.size() > 0; k++) @(negedge clk);
        #1;
        compareCount++;
        if (sbQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sbQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
